// File: rtl/dgiota_scan_seq.sv
// ---------------------------------------------------------------------------
// dgiota_scan_seq
//
// Analog-channel scan sequencer for the dgiota test tiles. Steps a one-hot
// select across up to CHANNELS analog test structures, holding each enabled
// channel for its programmable dwell time and strobing 'sample' in the final
// dwell cycle. Single-sweep or continuous operation, abortable with 'stop'.
//
// Optional feature macro: DGIOTA_SCAN_GAP_EN
//   defined   -> a GAP state inserts GAP_CYCLES cycles of sel=0 between every
//                pair of dwells (break-before-make), including the wrap.
//   undefined -> dwells are back to back; GAP_CYCLES has no effect.
//
// Parameters:
//   CHANNELS   : number of scanned channels (2..8)
//   DWELL_W    : width of each per-channel dwell register / counter
//   GAP_CYCLES : break-before-make gap length (1..15)
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cfg_we/addr/dwell : write one per-channel dwell register
//   cfg_mask_we/mask  : write the channel-enable mask
//   start, stop       : begin a scan (idle only) / abort the running scan
//   continuous        : repeat sweeps when set, latched at start
//   sel               : one-hot analog switch select (registered)
//   idx               : index of the current or most recent channel
//   sample            : strobe in the final dwell cycle of each channel
//   busy              : scan engine not idle
//   done              : one-cycle pulse when a single sweep completes
//   sweep_cnt         : completed sweeps, wraps at 256
// ---------------------------------------------------------------------------
module dgiota_scan_seq #(
   parameter int  CHANNELS   = 6,
   parameter int  DWELL_W    = 8,
   parameter int  GAP_CYCLES = 2,
   localparam int IW         = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [IW-1:0]       cfg_addr,
   input  logic [DWELL_W-1:0]  cfg_dwell,
   input  logic                cfg_mask_we,
   input  logic [CHANNELS-1:0] cfg_mask,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   output logic [CHANNELS-1:0] sel,
   output logic [IW-1:0]       idx,
   output logic                sample,
   output logic                busy,
   output logic                done,
   output logic [7:0]          sweep_cnt
);

   // Elaboration-time guards on the legal parameter ranges.
   if (CHANNELS < 2 || CHANNELS > 8) begin : gBadChannels
      $error("dgiota_scan_seq: CHANNELS must be in 2..8");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : gBadGap
      $error("dgiota_scan_seq: GAP_CYCLES must be in 1..15");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DWELL_W-1:0]  dwellReg_q [CHANNELS];
   logic [CHANNELS-1:0] mask_q;
   logic [CHANNELS-1:0] scanMask_q, scanMask_d;
   logic                cont_q, cont_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DWELL_W-1:0]  dwellCnt_q, dwellCnt_d;
   logic [7:0]          sweepCnt_q, sweepCnt_d;
   logic [CHANNELS-1:0] sel_q, sel_d;
   logic                sample_q, sample_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                higherFound;
   logic [IW-1:0]       higherIdx;
   logic                advance;
   logic [IW-1:0]       advIdx;
`ifdef DGIOTA_SCAN_GAP_EN
   logic [IW-1:0]       target_q, target_d;
   logic [3:0]          gapCnt_q, gapCnt_d;
`endif

   // Lowest set bit of an enable mask; callers only use it on nonzero masks.
   function automatic logic [IW-1:0] lowestOf(input logic [CHANNELS-1:0] m);
      logic [IW-1:0] r;
      r = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (m[i]) r = IW'(i);
      end
      return r;
   endfunction

   // A programmed dwell of zero still holds the channel for one cycle.
   function automatic logic [DWELL_W-1:0] effDwell(input logic [DWELL_W-1:0] d);
      return (d == '0) ? DWELL_W'(1) : d;
   endfunction

   // Configuration registers are writable at any time. The running scan only
   // picks them up at defined points: the mask at start, a dwell on entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            dwellReg_q[i] <= DWELL_W'(1);
         end
         mask_q <= '1;
      end else begin
         if (cfg_we && ({1'b0, cfg_addr} < (IW + 1)'(CHANNELS))) begin
            dwellReg_q[cfg_addr] <= cfg_dwell;
         end
         if (cfg_mask_we) begin
            mask_q <= cfg_mask;
         end
      end
   end

   // Sequencer state and all outputs are flopped, so the analog switches see
   // glitch-free selects and nothing combinational reaches the pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         scanMask_q <= '0;
         cont_q     <= 1'b0;
         idx_q      <= '0;
         dwellCnt_q <= '0;
         sweepCnt_q <= '0;
         sel_q      <= '0;
         sample_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef DGIOTA_SCAN_GAP_EN
         target_q   <= '0;
         gapCnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         scanMask_q <= scanMask_d;
         cont_q     <= cont_d;
         idx_q      <= idx_d;
         dwellCnt_q <= dwellCnt_d;
         sweepCnt_q <= sweepCnt_d;
         sel_q      <= sel_d;
         sample_q   <= sample_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef DGIOTA_SCAN_GAP_EN
         target_q   <= target_d;
         gapCnt_q   <= gapCnt_d;
`endif
      end
   end

   // Next-state logic. The dwell counter holds the cycles remaining including
   // the current one, so the final dwell cycle is the one where it reads 1.
   // Output next-values are decoded from the next state so that sel/sample
   // line up with the cycle they describe.
   always_comb begin
      state_d    = state_q;
      scanMask_d = scanMask_q;
      cont_d     = cont_q;
      idx_d      = idx_q;
      dwellCnt_d = dwellCnt_q;
      sweepCnt_d = sweepCnt_q;
      done_d     = 1'b0;
      advance    = 1'b0;
      advIdx     = '0;
`ifdef DGIOTA_SCAN_GAP_EN
      target_d   = target_q;
      gapCnt_d   = gapCnt_q;
`endif

      // Nearest enabled channel above the current one; descending scan so the
      // last hit is the lowest qualifying index.
      higherFound = 1'b0;
      higherIdx   = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (scanMask_q[i] && ((IW + 1)'(i) > {1'b0, idx_q})) begin
            higherFound = 1'b1;
            higherIdx   = IW'(i);
         end
      end

      case (state_q)
         IDLE: begin
            if (start && !stop && (mask_q != '0)) begin
               state_d    = DWELL;
               scanMask_d = mask_q;
               cont_d     = continuous;
               idx_d      = lowestOf(mask_q);
               dwellCnt_d = effDwell(dwellReg_q[idx_d]);
            end
         end
         DWELL: begin
            if (stop) begin
               state_d = IDLE;
            end else if (dwellCnt_q == DWELL_W'(1)) begin
               if (higherFound) begin
                  advance = 1'b1;
                  advIdx  = higherIdx;
               end else begin
                  sweepCnt_d = sweepCnt_q + 8'd1;
                  if (cont_q) begin
                     advance = 1'b1;
                     advIdx  = lowestOf(scanMask_q);
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end else begin
               dwellCnt_d = dwellCnt_q - DWELL_W'(1);
            end
         end
`ifdef DGIOTA_SCAN_GAP_EN
         GAP: begin
            if (stop) begin
               state_d = IDLE;
            end else if (gapCnt_q == 4'd1) begin
               state_d    = DWELL;
               idx_d      = target_q;
               dwellCnt_d = effDwell(dwellReg_q[target_q]);
            end else begin
               gapCnt_d = gapCnt_q - 4'd1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // Moving to another channel: either park in GAP with the target
      // remembered, or jump straight into the next dwell.
      if (advance) begin
`ifdef DGIOTA_SCAN_GAP_EN
         state_d  = GAP;
         target_d = advIdx;
         gapCnt_d = 4'(GAP_CYCLES);
`else
         state_d    = DWELL;
         idx_d      = advIdx;
         dwellCnt_d = effDwell(dwellReg_q[advIdx]);
`endif
      end

      sel_d    = (state_d == DWELL) ? (CHANNELS'(1) << idx_d) : '0;
      sample_d = (state_d == DWELL) && (dwellCnt_d == DWELL_W'(1));
      busy_d   = (state_d != IDLE);
   end

   assign sel       = sel_q;
   assign idx       = idx_q;
   assign sample    = sample_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sweep_cnt = sweepCnt_q;

endmodule

// File: tb/tb_dgiota_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_dgiota_scan_seq
//
// Directed self-checking bench for dgiota_scan_seq with default parameters
// (6 channels, 8-bit dwell). Expected per-cycle sel/sample traces are built
// from hand-listed channel/dwell sequences; the gap length follows the
// DGIOTA_SCAN_GAP_EN build (2 cycles when defined, none otherwise).
// ---------------------------------------------------------------------------
module tb_dgiota_scan_seq;

`ifdef DGIOTA_SCAN_GAP_EN
   localparam int GAP = 2;
`else
   localparam int GAP = 0;
`endif

   logic       clk;
   logic       rst;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_dwell;
   logic       cfg_mask_we;
   logic [5:0] cfg_mask;
   logic       start;
   logic       stop;
   logic       continuous;
   logic [5:0] sel;
   logic [2:0] idx;
   logic       sample;
   logic       busy;
   logic       done;
   logic [7:0] sweep_cnt;

   int vecCount  = 0;
   int missCount = 0;

   logic [5:0] expSel[$];
   logic       expSample[$];

   dgiota_scan_seq dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_dwell  (cfg_dwell),
      .cfg_mask_we(cfg_mask_we),
      .cfg_mask   (cfg_mask),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .sel        (sel),
      .idx        (idx),
      .sample     (sample),
      .busy       (busy),
      .done       (done),
      .sweep_cnt  (sweep_cnt)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a bounded wait was miscoded.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected-trace builders: one entry per clock cycle.
   task automatic clearTrace();
      expSel.delete();
      expSample.delete();
   endtask

   task automatic addDwell(input int ch, input int d);
      logic [5:0] one;
      one = 6'd1;
      for (int j = 0; j < d; j++) begin
         expSel.push_back(one << ch);
         expSample.push_back(j == d - 1);
      end
   endtask

   task automatic addGap();
      for (int j = 0; j < GAP; j++) begin
         expSel.push_back(6'd0);
         expSample.push_back(1'b0);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0; stop = 1'b0; continuous = 1'b0;
      cfg_we = 1'b0; cfg_mask_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic writeDwell(input logic [2:0] a, input logic [7:0] v);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_dwell = v;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic writeMask(input logic [5:0] m);
      @(negedge clk);
      cfg_mask_we = 1'b1; cfg_mask = m;
      @(negedge clk);
      cfg_mask_we = 1'b0;
   endtask

   // Reset values while reset is held and right after release.
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vecCount++;
      if ({sel, idx, sample, busy, done, sweep_cnt} !== 20'd0) begin
         missCount++;
         $display("[TB] FAIL reset_hold: got sel=%b idx=%0d sample=%b busy=%b done=%b cnt=%0d, expected all zero",
                  sel, idx, sample, busy, done, sweep_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
      vecCount++;
      if (busy !== 1'b0 || sel !== 6'd0) begin
         missCount++;
         $display("[TB] FAIL reset_release: got busy=%b sel=%b, expected busy=0 sel=000000", busy, sel);
      end
   endtask

   // Default config: every channel for one cycle, sample on each.
   task automatic test_default_sweep();
      clearTrace();
      for (int c = 0; c < 6; c++) begin
         addDwell(c, 1);
         if (c < 5) addGap();
      end
      @(negedge clk);
      continuous = 1'b0; start = 1'b1;
      for (int k = 0; k < expSel.size(); k++) begin
         @(negedge clk);
         start = 1'b0;
         vecCount++;
         if (sel !== expSel[k] || sample !== expSample[k] || busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL default_trace cyc %0d: got sel=%b sample=%b busy=%b, expected sel=%b sample=%b busy=1",
                     k, sel, sample, busy, expSel[k], expSample[k]);
         end
      end
      @(negedge clk);
      vecCount++;
      if (done !== 1'b1 || busy !== 1'b0 || sweep_cnt !== 8'd1 || sel !== 6'd0 || idx !== 3'd5) begin
         missCount++;
         $display("[TB] FAIL default_done: got done=%b busy=%b cnt=%0d sel=%b idx=%0d, expected 1 0 1 000000 5",
                  done, busy, sweep_cnt, sel, idx);
      end
      @(negedge clk);
      vecCount++;
      if (done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL default_done_width: got done=%b, expected 0", done);
      end
   endtask

   // Mask 100101 with dwells 3 / 0 / 4: visits 0, 2, 5 for 3, 1, 4 cycles.
   task automatic test_masked_dwell();
      int samples;
      doReset();
      writeMask(6'b100101);
      writeDwell(3'd0, 8'd3);
      writeDwell(3'd2, 8'd0);
      writeDwell(3'd5, 8'd4);
      clearTrace();
      addDwell(0, 3); addGap(); addDwell(2, 1); addGap(); addDwell(5, 4);
      samples = 0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < expSel.size(); k++) begin
         @(negedge clk);
         start = 1'b0;
         samples += int'(sample);
         vecCount++;
         if (sel !== expSel[k] || sample !== expSample[k]) begin
            missCount++;
            $display("[TB] FAIL masked_trace cyc %0d: got sel=%b sample=%b, expected sel=%b sample=%b",
                     k, sel, sample, expSel[k], expSample[k]);
         end
      end
      @(negedge clk);
      samples += int'(sample);
      vecCount++;
      if (samples != 3 || done !== 1'b1 || sweep_cnt !== 8'd1) begin
         missCount++;
         $display("[TB] FAIL masked_end: got samples=%0d done=%b cnt=%0d, expected 3 1 1", samples, done, sweep_cnt);
      end
   endtask

   // Continuous 0,1,0,1 with dwell 2, then stop in the first cycle of a dwell.
   task automatic test_continuous_stop();
      doReset();
      writeMask(6'b000011);
      writeDwell(3'd0, 8'd2);
      writeDwell(3'd1, 8'd2);
      clearTrace();
      addDwell(0, 2); addGap(); addDwell(1, 2); addGap();
      addDwell(0, 2); addGap(); addDwell(1, 2);
      @(negedge clk);
      continuous = 1'b1; start = 1'b1;
      for (int k = 0; k < expSel.size(); k++) begin
         @(negedge clk);
         start = 1'b0;
         vecCount++;
         if (sel !== expSel[k] || sample !== expSample[k]) begin
            missCount++;
            $display("[TB] FAIL cont_trace cyc %0d: got sel=%b sample=%b, expected sel=%b sample=%b",
                     k, sel, sample, expSel[k], expSample[k]);
         end
      end
      vecCount++;
      if (sweep_cnt !== 8'd1) begin
         missCount++;
         $display("[TB] FAIL cont_cnt1: got cnt=%0d, expected 1", sweep_cnt);
      end
      @(negedge clk);
      vecCount++;
      if (sweep_cnt !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL cont_cnt2: got cnt=%0d busy=%b done=%b, expected 2 1 0", sweep_cnt, busy, done);
      end
      repeat (GAP) @(negedge clk);
      vecCount++;
      if (sel !== 6'b000001 || sample !== 1'b0 || idx !== 3'd0) begin
         missCount++;
         $display("[TB] FAIL cont_wrap: got sel=%b sample=%b idx=%0d, expected 000001 0 0", sel, sample, idx);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      continuous = 1'b0;
      vecCount++;
      if (sel !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || sample !== 1'b0 || sweep_cnt !== 8'd2) begin
         missCount++;
         $display("[TB] FAIL stop_idle: got sel=%b busy=%b done=%b sample=%b cnt=%0d, expected 000000 0 0 0 2",
                  sel, busy, done, sample, sweep_cnt);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vecCount++;
         if (done !== 1'b0 || busy !== 1'b0 || sweep_cnt !== 8'd2) begin
            missCount++;
            $display("[TB] FAIL stop_hold cyc %0d: got done=%b busy=%b cnt=%0d, expected 0 0 2", k, done, busy, sweep_cnt);
         end
      end
   endtask

   // Zero mask, start+stop together, and start while a sweep is running.
   task automatic test_edge_cases();
      doReset();
      writeMask(6'd0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vecCount++;
         if (busy !== 1'b0 || sel !== 6'd0) begin
            missCount++;
            $display("[TB] FAIL zero_mask cyc %0d: got busy=%b sel=%b, expected 0 000000", k, busy, sel);
         end
         @(negedge clk);
      end
      writeMask(6'b111111);
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vecCount++;
         if (busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL start_stop cyc %0d: got busy=%b, expected 0", k, busy);
         end
         @(negedge clk);
      end
      clearTrace();
      for (int c = 0; c < 6; c++) begin
         addDwell(c, 1);
         if (c < 5) addGap();
      end
      start = 1'b1;
      for (int k = 0; k < expSel.size(); k++) begin
         @(negedge clk);
         start = (k == 2 || k == 3);
         continuous = start;
         vecCount++;
         if (sel !== expSel[k] || sample !== expSample[k]) begin
            missCount++;
            $display("[TB] FAIL busy_start cyc %0d: got sel=%b sample=%b, expected sel=%b sample=%b",
                     k, sel, sample, expSel[k], expSample[k]);
         end
      end
      @(negedge clk);
      vecCount++;
      if (done !== 1'b1 || busy !== 1'b0 || sweep_cnt !== 8'd1) begin
         missCount++;
         $display("[TB] FAIL busy_start_done: got done=%b busy=%b cnt=%0d, expected 1 0 1", done, busy, sweep_cnt);
      end
   endtask

   // 256 continuous sweeps wrap the counter; async reset mid-dwell restores
   // outputs at once and config to defaults.
   task automatic test_wrap_reset();
      int cyc;
      doReset();
      writeMask(6'b000001);
      writeDwell(3'd2, 8'd7);
      @(negedge clk);
      continuous = 1'b1; start = 1'b1;
      for (int n = 0; n < 3000 && sweep_cnt !== 8'd255; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      vecCount++;
      if (sweep_cnt !== 8'd255) begin
         missCount++;
         $display("[TB] FAIL wrap_reach255: got cnt=%0d, expected 255 within budget", sweep_cnt);
      end
      cyc = 0;
      for (int n = 0; n < 20 && sweep_cnt === 8'd255; n++) begin
         @(negedge clk);
         cyc++;
      end
      vecCount++;
      if (sweep_cnt !== 8'd0 || cyc != 1 + GAP) begin
         missCount++;
         $display("[TB] FAIL wrap_zero: got cnt=%0d after %0d cycles, expected 0 after %0d", sweep_cnt, cyc, 1 + GAP);
      end
      for (int n = 0; n < 10 && sel === 6'd0; n++) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      vecCount++;
      if ({sel, idx, sample, busy, done, sweep_cnt} !== 20'd0) begin
         missCount++;
         $display("[TB] FAIL async_reset: got sel=%b idx=%0d sample=%b busy=%b done=%b cnt=%0d, expected all zero",
                  sel, idx, sample, busy, done, sweep_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      continuous = 1'b0;
      clearTrace();
      for (int c = 0; c < 6; c++) begin
         addDwell(c, 1);
         if (c < 5) addGap();
      end
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < expSel.size(); k++) begin
         @(negedge clk);
         start = 1'b0;
         vecCount++;
         if (sel !== expSel[k] || sample !== expSample[k]) begin
            missCount++;
            $display("[TB] FAIL post_reset_trace cyc %0d: got sel=%b sample=%b, expected sel=%b sample=%b",
                     k, sel, sample, expSel[k], expSample[k]);
         end
      end
      @(negedge clk);
      vecCount++;
      if (done !== 1'b1 || sweep_cnt !== 8'd1) begin
         missCount++;
         $display("[TB] FAIL post_reset_done: got done=%b cnt=%0d, expected 1 1", done, sweep_cnt);
      end
   endtask

   // Rewrite dwell[3] during channel 1 (applies later this sweep) and
   // rewrite dwell[1] while channel 1 is active (must not lengthen it).
   task automatic test_midscan_dwell();
      doReset();
      writeMask(6'b001011);
      writeDwell(3'd1, 8'd3);
      clearTrace();
      addDwell(0, 1); addGap(); addDwell(1, 3); addGap(); addDwell(3, 4);
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < expSel.size(); k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 1 + GAP) begin
            cfg_we = 1'b1; cfg_addr = 3'd3; cfg_dwell = 8'd4;
         end else if (k == 2 + GAP) begin
            cfg_we = 1'b1; cfg_addr = 3'd1; cfg_dwell = 8'd6;
         end else begin
            cfg_we = 1'b0;
         end
         vecCount++;
         if (sel !== expSel[k] || sample !== expSample[k]) begin
            missCount++;
            $display("[TB] FAIL midscan_trace cyc %0d: got sel=%b sample=%b, expected sel=%b sample=%b",
                     k, sel, sample, expSel[k], expSample[k]);
         end
      end
      @(negedge clk);
      vecCount++;
      if (done !== 1'b1 || idx !== 3'd3) begin
         missCount++;
         $display("[TB] FAIL midscan_done: got done=%b idx=%0d, expected 1 3", done, idx);
      end
   endtask

   initial begin
      rst = 1'b1;
      cfg_we = 1'b0; cfg_addr = 3'd0; cfg_dwell = 8'd0;
      cfg_mask_we = 1'b0; cfg_mask = 6'd0;
      start = 1'b0; stop = 1'b0; continuous = 1'b0;
      test_reset();
      test_default_sweep();
      test_masked_dwell();
      test_continuous_stop();
      test_edge_cases();
      test_wrap_reset();
      test_midscan_dwell();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
